// File: rtl/cdc_handshake_src_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_src_pkg
// Purpose  : Shared types and defaults for the 4-phase CDC source block:
//            FSM state encoding, default parameters, counter sizing helper.
// Revision : 1.0 - initial release
// ============================================================================
package cdc_handshake_src_pkg;

  // Default parameter values for cdc_handshake_src
  localparam int C_DEF_BW             = 32;
  localparam int C_DEF_TIMEOUT_CYCLES = 1024;

  // Depth of the ack synchronizer; also the number of cycles after reset
  // before the synchronized ack reflects the real line level.
  localparam logic [1:0] C_SYNC_STAGES = 2'd2;

  // Handshake FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  // Width needed for a phase counter that must be able to hold the value tmo
  function automatic int cnt_width(input int tmo);
    return (tmo < 2) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/single_bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : single_bit_sync
// Purpose  : Two-flop synchronizer for a single level signal coming from an
//            unrelated clock domain. Both flops reset to RST_VAL.
// Revision : 1.0 - initial release
// ============================================================================
module single_bit_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/cdc_handshake_src.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_src
// Purpose  : Source side of a 4-phase req/ack clock-domain-crossing
//            handshake. Accepts one word at a time, holds it on xfer_data
//            while xfer_req is high, counts completed transfers and flags
//            handshake phases that take too long.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_src
  import cdc_handshake_src_pkg::*;
#(
  parameter int BW             = C_DEF_BW,
  parameter int TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  output logic          xfer_req,
  output logic [BW-1:0] xfer_data,
  input  logic          xfer_ack,
  output logic          done,
  output logic          err_timeout,
  input  logic          err_clr,
  output logic [15:0]   xfer_cnt
);

  state_t        state_q, state_d;
  logic [BW-1:0] xfer_data_q, xfer_data_d;
  logic          xfer_req_q, xfer_req_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [1:0]    warm_q, warm_d;

  logic          ack_s;
  logic          warm_ok;
  logic          ready_c;
  logic          tmo_hit;

  // Only the synchronized ack is ever looked at by this domain
  single_bit_sync #(
    .RST_VAL (1'b0)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (xfer_ack),
    .q_o (ack_s)
  );

  // The synchronizer restarts from 0 on reset; until it has refilled, ack_s
  // would falsely report a released ack, so acceptance is held off.
  assign warm_ok = (warm_q == C_SYNC_STAGES);
  assign warm_d  = warm_ok ? warm_q : (warm_q + 2'd1);

  // Next-state, acceptance and completion decode
  always_comb begin
    state_d     = state_q;
    xfer_data_d = xfer_data_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    ready_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = ~ack_s & warm_ok;
        if (in_valid && ready_c) begin
          xfer_data_d = in_data;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_d = ST_REL;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_REL: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request is a pure function of the next state so it is glitch-free
  assign xfer_req_d = (state_d == ST_REQ);

  // Set dominates clear so a timeout landing on a clear is never lost
  assign err_d = (err_q & ~err_clr) | tmo_hit;

  // Phase watchdog: cleared on every state change, counts while waiting for
  // the far side, saturates at the limit. It only reports; it never aborts.
  if (TIMEOUT_CYCLES > 0) begin : g_tmo
    localparam int          CW         = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] C_TMO    = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] C_TMO_M1 = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] phase_q, phase_d;
    logic          waiting;

    assign waiting = (state_q != ST_IDLE) && (state_d == state_q);
    assign tmo_hit = waiting && (phase_q == C_TMO_M1);

    // Phase counter next value
    always_comb begin
      phase_d = phase_q;
      if (state_d != state_q) begin
        phase_d = '0;
      end else if (waiting && (phase_q != C_TMO)) begin
        phase_d = phase_q + 1'b1;
      end
    end

    // Phase counter register
    always_ff @(posedge clk) begin
      if (rst) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_d;
      end
    end
  end else begin : g_no_tmo
    assign tmo_hit = 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      xfer_data_q <= '0;
      xfer_req_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 16'd0;
      warm_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      xfer_data_q <= xfer_data_d;
      xfer_req_q  <= xfer_req_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      warm_q      <= warm_d;
    end
  end

  assign in_ready    = ready_c;
  assign xfer_req    = xfer_req_q;
  assign xfer_data   = xfer_data_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign xfer_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: doc/cdc_handshake_src.md
CDC_HANDSHAKE_SRC -- requirements
Module: cdc_handshake_src

Interface
REQ-001 SHALL have parameter BW, default 32: width of transferred word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles allowed per handshake phase; 0 disables timeout.
REQ-003 SHALL have port clk  input  1  single clock of the source domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  source word available.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_data  input  BW  source word.
REQ-008 SHALL have port xfer_req  output  1  4-phase request to destination domain, registered.
REQ-009 SHALL have port xfer_data  output  BW  held word, registered, stable while xfer_req=1.
REQ-010 SHALL have port xfer_ack  input  1  4-phase acknowledge from destination domain, asynchronous to clk.
REQ-011 SHALL have port done  output  1  one-cycle pulse: destination has taken the word.
REQ-012 SHALL have port err_timeout  output  1  sticky timeout flag.
REQ-013 SHALL have port err_clr  input  1  clears err_timeout.
REQ-014 SHALL have port xfer_cnt  output  16  completed-transfer count, wraps 0xFFFF->0x0000.

Function
REQ-015 SHALL pass xfer_ack through a 2-flop synchronizer; ack_s denotes its output; no other logic samples raw xfer_ack.
REQ-016 SHALL implement FSM states IDLE, REQ, REL.
REQ-017 IDLE: in_ready=1 iff ack_s=0; no word is accepted while a stale ack_s=1 persists.
REQ-018 IDLE with in_valid&in_ready: latch in_data into xfer_data, next state REQ; xfer_req=1 on the next cycle.
REQ-019 REQ: xfer_req=1; on ack_s=1 -> REL, with done pulsed in the same cycle as the transition and xfer_cnt incremented.
REQ-020 REL: xfer_req=0; on ack_s=0 -> IDLE.
REQ-021 xfer_data SHALL change only on acceptance in IDLE.
REQ-022 Minimum round trip SHALL be accept at cycle 0, xfer_req high from cycle 1, in_ready high again no earlier than 2 cycles after xfer_ack falls.
REQ-023 Phase counter SHALL clear on each state entry, count in REQ and REL, and saturate; reaching TIMEOUT_CYCLES SHALL set err_timeout; the FSM keeps waiting and does not abort.
REQ-024 err_clr SHALL clear err_timeout; simultaneous set and clear SHALL leave err_timeout=1.
REQ-025 in_valid SHALL be ignored outside IDLE; in_data SHALL not be sampled outside acceptance.

Reset
REQ-026 rst SHALL force state IDLE, xfer_req=0, xfer_data=0, done=0, err_timeout=0, xfer_cnt=0, phase counter=0, synchronizer flops=0.
REQ-027 Reset mid-handshake SHALL drop xfer_req the following cycle; after reset, in_ready SHALL stay 0 until ack_s=0 (REQ-017).

Structure
REQ-028 State encoding and the default parameter values SHALL live in the shared package include for the pcore.
REQ-029 The ack synchronizer SHALL be one instance of single_bit_sync (RST_VAL=0), clocked by clk and reset by rst.

Verification
REQ-030 Single transfer: in_data=0xA5A5_0001 and in_valid pulse; ack follows req after 3 cycles and drops 3 cycles after req drops -> xfer_data=0xA5A5_0001 held, done one pulse, xfer_cnt=1.
REQ-031 Back-to-back: in_valid held with words 1..4 -> exactly 4 acceptances, xfer_req never high in IDLE, xfer_cnt=4.
REQ-032 Timeout: TIMEOUT_CYCLES=16, ack never rises -> err_timeout=1 after 16 REQ cycles, xfer_req still 1; a late ack completes the transfer normally.
REQ-033 Clear race: err_clr pulsed in the same cycle as a new timeout -> err_timeout stays 1; err_clr alone one cycle later -> 0.
REQ-034 Reset mid-REQ, ack held 1 -> xfer_req=0 one cycle later; in_ready=0 until ack falls, plus 2 cycles.
REQ-035 Wrap: preload by running 65536 transfers -> xfer_cnt=0x0000.
